// File: rtl/fp_acc3_sched.sv
// rtl/fp_acc3_sched.sv - FP vector reduction scheduler around a 3-operand FP adder; ACC_CNT_EN adds the out_cnt element counter

// Three-operand FP adder with one register stage. The sum is aligned to the
// largest exponent. Rounding is by truncation. Denormals flush to zero and
// overflow saturates to infinity. The output register loads the sum when
// i_sync is high and clears to +0.0 otherwise.
module fp_adder3 #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
) (
    input  logic                       clk,
    input  logic                       i_sync,
    input  logic [EXPONENT+MANTISSA:0] i_a1,
    input  logic [EXPONENT+MANTISSA:0] i_a2,
    input  logic [EXPONENT+MANTISSA:0] i_a3,
    output logic [EXPONENT+MANTISSA:0] o_sum
);
    localparam int W  = EXPONENT + MANTISSA + 1;
    localparam int G  = 3;                 // guard bits kept below the mantissa while aligning
    localparam int MW = MANTISSA + 1 + G;  // hidden bit + mantissa + guard
    localparam int SW = MW + 3;            // headroom for a 3-way sum plus sign

    logic [W-1:0]        w_op [3];
    logic [EXPONENT-1:0] w_emax;
    logic [MW-1:0]       w_al;
    logic [SW-1:0]       w_total;
    logic [SW-1:0]       w_mag;
    logic [SW-1:0]       w_norm;
    logic                w_neg;
    int                  w_p;
    int                  w_exp;
    logic [MANTISSA-1:0] w_frac;
    logic [W-1:0]        w_res;
    logic [W-1:0]        r_sum;

    assign w_op[0] = i_a1;
    assign w_op[1] = i_a2;
    assign w_op[2] = i_a3;

    // Align to the largest exponent, add as signed integers, then renormalise
    always_comb begin
        w_emax = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_op[k][W-2:MANTISSA] > w_emax) w_emax = w_op[k][W-2:MANTISSA];
        end
        w_total = '0;
        w_al    = '0;
        for (int k = 0; k < 3; k++) begin
            w_al = (w_op[k][W-2:MANTISSA] == '0) ? '0 : {1'b1, w_op[k][MANTISSA-1:0], {G{1'b0}}};
            w_al = w_al >> (w_emax - w_op[k][W-2:MANTISSA]);
            if (w_op[k][W-1]) w_total = w_total - {3'b000, w_al};
            else              w_total = w_total + {3'b000, w_al};
        end
        w_neg = w_total[SW-1];
        w_mag = w_neg ? (~w_total + SW'(1)) : w_total;
        w_p   = 0;
        for (int i = 0; i < SW; i++) begin
            if (w_mag[i]) w_p = i;
        end
        w_norm = w_mag << (SW - 1 - w_p);
        w_frac = MANTISSA'(w_norm >> (SW - 1 - MANTISSA));
        w_exp  = int'(w_emax) + w_p - (MANTISSA + G);
        if (w_mag == '0 || w_exp <= 0)
            w_res = '0;
        else if (w_exp >= (1 << EXPONENT) - 1)
            w_res = {w_neg, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
        else
            w_res = {w_neg, EXPONENT'(w_exp), w_frac};
    end

    // Single pipeline stage, cleared whenever no pass is issued
    always_ff @(posedge clk) begin
        r_sum <= i_sync ? w_res : '0;
    end

    assign o_sum = r_sum;
endmodule

module fp_acc3_sched #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
`ifdef ACC_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXPONENT+MANTISSA:0] in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXPONENT+MANTISSA:0] out_data
`ifdef ACC_CNT_EN
    ,
    output logic [CNT_W-1:0]           out_cnt
`endif
);
    localparam int W = EXPONENT + MANTISSA + 1;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   r_cnt;
    logic [W-1:0] r_op0;
    logic [W-1:0] r_op1;
    logic [W-1:0] r_acc;
    logic         r_last_f;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         w_in_fire;
    logic         w_sync;
    logic [W-1:0] w_a2;
    logic [W-1:0] w_sum;

    assign in_ready  = !rst && (r_state == S_COLLECT);
    assign w_in_fire = in_valid && in_ready;
    assign w_sync    = (r_state == S_ISSUE);
    // An odd tail issues a single element; the second slot adds +0.0
    assign w_a2      = (r_cnt == 2'd2) ? r_op1 : '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    fp_adder3 #(
        .EXPONENT (EXPONENT),
        .MANTISSA (MANTISSA)
    ) u_adder (
        .clk    (clk),
        .i_sync (w_sync),
        .i_a1   (r_op0),
        .i_a2   (w_a2),
        .i_a3   (r_acc),
        .o_sum  (w_sum)
    );

    // Collect a pair, issue it with the running sum, capture, and emit at vector end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_cnt       <= 2'd0;
            r_op0       <= '0;
            r_op1       <= '0;
            r_acc       <= '0;
            r_last_f    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_in_fire) begin
                        if (r_cnt == 2'd0) r_op0 <= in_data;
                        else               r_op1 <= in_data;
                        r_cnt    <= r_cnt + 2'd1;
                        r_last_f <= in_last;
                        if (r_cnt == 2'd1 || in_last) r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_acc <= w_sum;
                    r_cnt <= 2'd0;
                    if (r_last_f) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_last_f    <= 1'b0;
                        r_state     <= S_COLLECT;
                    end
                end
            endcase
        end
    end

`ifdef ACC_CNT_EN
    logic [CNT_W-1:0] r_elem_cnt;
    logic [CNT_W-1:0] r_out_cnt;

    // Saturating element count, published alongside the vector sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_elem_cnt <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_in_fire && r_elem_cnt != '1) r_elem_cnt <= r_elem_cnt + CNT_W'(1);
            if (r_state == S_CAPTURE && r_last_f) r_out_cnt <= r_elem_cnt;
            if (r_state == S_OUTPUT && out_ready) begin
                r_elem_cnt <= '0;
                r_out_cnt  <= '0;
            end
        end
    end

    assign out_cnt = r_out_cnt;
`endif
endmodule

// File: tb/tb_fp_acc3_sched.sv
// tb/tb_fp_acc3_sched.sv - self-checking bench for fp_acc3_sched with a real-arithmetic reference model
module tb_fp_acc3_sched;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef ACC_CNT_EN
    logic [15:0] out_cnt;
`endif

    int          n_chk;
    int          n_err;
    int          cyc;
    int          last_acc;
    real         vsum;
    int          vcnt;
    logic [31:0] exp_q [$];
    int          cnt_q [$];
    logic        p_valid;
    logic        p_ready;
    logic [31:0] p_data;
    logic [31:0] m_e;
    int          m_c;
    logic [31:0] got_d;
    int          got_c;

    fp_acc3_sched #(
        .EXPONENT (8),
        .MANTISSA (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef ACC_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic real fp2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic        s;
        real         a;
        int          e;
        logic [22:0] f;
        logic [7:0]  eb;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f  = 23'($rtoi((a - 1.0) * 8388608.0));
        eb = 8'(e);
        return {s, eb, f};
    endfunction

    // Compare process: protocol rules plus model-predicted sums, every cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            vsum    = 0.0;
            vcnt    = 0;
            p_valid = 1'b0;
            p_ready = 1'b0;
        end else begin
            if (out_valid) chk("busy_in_ready", 32'(in_ready), 32'd0);
            if (p_valid && p_ready) begin
                chk("hs_drop_valid", 32'(out_valid), 32'd0);
                chk("b2b_in_ready", 32'(in_ready), 32'd1);
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, p_data);
            end
            if (out_valid && !p_valid) chk("latency", 32'(cyc), 32'(last_acc + 3));
            if (in_valid && in_ready) begin
                vsum += fp2r(in_data);
                vcnt++;
                if (in_last) begin
                    exp_q.push_back(r2fp(vsum));
                    cnt_q.push_back(vcnt > 65535 ? 65535 : vcnt);
                    last_acc = cyc;
                    vsum = 0.0;
                    vcnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    m_c = cnt_q.pop_front();
                    if (m_e == 32'h0) chk("model_sum_zero", out_data & 32'h7FFF_FFFF, 32'h0);
                    else              chk("model_sum", out_data, m_e);
`ifdef ACC_CNT_EN
                    chk("model_cnt", 32'(out_cnt), 32'(m_c));
`endif
                end
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_data  = out_data;
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_out(input int hold, output logic [31:0] d, output int c);
        int t;
        t = 0;
        d = '0;
        c = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            chk("out_timeout", 32'(out_valid), 32'd1);
            return;
        end
        d = out_data;
`ifdef ACC_CNT_EN
        c = 32'(out_cnt);
`endif
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; last_acc = -100;
        vsum = 0.0; vcnt = 0;
        p_valid = 1'b0; p_ready = 1'b0; p_data = '0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
`ifdef ACC_CNT_EN
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1) four elements, pair completes on last
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b0);
        send(32'h4080_0000, 1'b1);
        get_out(0, got_d, got_c);
        chk("t1_sum", got_d, 32'h4120_0000);
`ifdef ACC_CNT_EN
        chk("t1_cnt", 32'(got_c), 32'd4);
`endif

        // 2+5) single element, out_ready withheld for 5 cycles
        send(32'h4040_0000, 1'b1);
        get_out(5, got_d, got_c);
        chk("t2_sum", got_d, 32'h4040_0000);
`ifdef ACC_CNT_EN
        chk("t2_cnt", 32'(got_c), 32'd1);
`endif

        // 3) odd vector with an input gap, then back-to-back single
        send(32'h3F80_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        get_out(0, got_d, got_c);
        chk("t3_sum", got_d, 32'h40C0_0000);
        send(32'h3F80_0000, 1'b1);
        get_out(0, got_d, got_c);
        chk("t3b_sum", got_d, 32'h3F80_0000);

        // 4) cancellation to zero
        send(32'h3F80_0000, 1'b0);
        send(32'hBF80_0000, 1'b1);
        get_out(0, got_d, got_c);
        chk("t4_zero", got_d & 32'h7FFF_FFFF, 32'h0);

        // 6) reset mid-vector discards the partial sum
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'h4000_0000, 1'b1);
        get_out(0, got_d, got_c);
        chk("t6_sum", got_d, 32'h4000_0000);
`ifdef ACC_CNT_EN
        chk("t6_cnt", 32'(got_c), 32'd1);
`endif

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
